serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
// - Bit-serial unsigned subtractor: diff = minuend - subtrahend, one bit per clock, LSB first.
// - Datapath is a single half/full-subtractor cell plus a registered borrow.
// - Complements the combinational adder cells as the area-minimal inverse operation.
// - valid/ready handshake on both sides, so it drops into streaming datapaths.
// PARAMETERS
// - WIDTH  8  operand/result width in bits; legal range >= 2
// PORTS
// - clk         input   1      single clock; all state updates on rising edge
// - rst         input   1      asynchronous, active-high reset
// - in_valid    input   1      operands valid
// - in_ready    output  1      block can accept operands
// - minuend     input   WIDTH  operand a
// - subtrahend  input   WIDTH  operand b
// - out_valid   output  1      diff/borrow valid
// - out_ready   input   1      consumer accepts result
// - diff        output  WIDTH  result, a - b mod 2^WIDTH
// - borrow      output  1      final borrow: 1 when a < b
// - busy        output  1      high in RUN
// BEHAVIOUR
// - Reset (async assert, sync-safe deassert): state=IDLE.
//   - out_valid=0, diff=0, borrow=0, busy=0; in_ready=0 while rst high.
// - FSM states: IDLE -> RUN -> DONE -> IDLE.
// - IDLE:
//   - in_ready=1.
//   - Accept edge (in_valid & in_ready): latch a, b into shift regs; borrow reg=0; bit count=0; go RUN.
// - RUN:
//   - in_ready=0 and busy=1; in_valid is ignored.
//   - Each edge processes bit i = shift-reg LSB, with br the current borrow reg:
//     - d  = a_i ^ b_i ^ br
//     - br' = (~a_i & b_i) | (~(a_i ^ b_i) & br)
//   - diff <= {d, diff[WIDTH-1:1]}; operand regs shift right; count++.
//   - After WIDTH RUN edges go to DONE.
// - DONE:
//   - out_valid=1; diff and borrow held stable until out_ready=1.
//   - Edge with out_valid & out_ready: go IDLE, out_valid=0.
//   - in_ready stays 0 in DONE; no overlap of operations.
// - Latency: out_valid rises exactly WIDTH edges after the accept edge.
// - Throughput: one result per WIDTH+2 cycles minimum.
// - Counter width is $clog2(WIDTH+1); the count never wraps.
// - diff contents during RUN are don't-care; only DONE values are specified.
// - Reset mid-RUN or mid-DONE: operation is abandoned, no out_valid; IDLE on first edge after release.
// - out_ready while not in DONE: ignored.
// CONFIGURATION
// - Macro SERIAL_SUB_SAT_EN:
//   - Defined: on entering DONE with borrow=1, diff is forced to 0 (saturate at zero); borrow still 1.
//   - Undefined: diff is the wrapped result mod 2^WIDTH.
// TESTING (WIDTH=8)
// - a=0x05, b=0x03 -> diff=0x02, borrow=0; out_valid exactly 8 edges after accept.
// - a=0x03, b=0x05 -> diff=0xFE, borrow=0x1 (SAT_EN: diff=0x00, borrow=1).
// - a=0x00, b=0x00 -> diff=0x00, b=0; a=0xFF, b=0xFF -> 0x00, 0; a=0x00, b=0x01 -> 0xFF, 1.
// - out_ready low 5 cycles in DONE -> diff/borrow/out_valid stable, in_ready=0; then handshake -> IDLE, in_ready=1.
// - in_valid toggled with new operands during RUN -> ignored; the first result is unchanged.
// - rst pulse after 4 RUN edges -> out_valid never asserts, in_ready=1 after release; next op 0x80-0x01 -> 0x7F, borrow=0.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor (diff = minuend - subtrahend), LSB first, valid/ready on both sides.
// Define SERIAL_SUB_SAT_EN to clamp diff to zero when the final borrow is set.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] minuend,
   input  logic [WIDTH-1:0] subtrahend,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] diff_r;
   logic             br;
   logic [CW-1:0]    cnt;

   logic             ai;
   logic             bi;
   logic             d;
   logic             br_nxt;
   logic             last;
   logic [WIDTH-1:0] diff_nxt;

   // Single full-subtractor cell fed by the operand LSBs and the registered borrow.
   always_comb begin
      ai       = a_sr[0];
      bi       = b_sr[0];
      d        = ai ^ bi ^ br;
      br_nxt   = (~ai & bi) | (~(ai ^ bi) & br);
      last     = (cnt == CW'(WIDTH - 1));
      diff_nxt = {d, diff_r[WIDTH-1:1]};
`ifdef SERIAL_SUB_SAT_EN
      // Saturation applied on the final bit so diff is already clamped when DONE is entered.
      if (last && br_nxt) begin
         diff_nxt = '0;
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         a_sr   <= '0;
         b_sr   <= '0;
         diff_r <= '0;
         br     <= 1'b0;
         cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sr  <= minuend;
                  b_sr  <= subtrahend;
                  br    <= 1'b0;
                  cnt   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
               b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
               br     <= br_nxt;
               diff_r <= diff_nxt;
               cnt    <= cnt + CW'(1);
               if (last) begin
                  state <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      in_ready  = (state == IDLE) && !rst;
      out_valid = (state == DONE);
      busy      = (state == RUN);
      diff      = diff_r;
      borrow    = br;
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8); expected results come from integer subtraction.
// Build with SERIAL_SUB_SAT_EN defined to check the saturating variant.
module tb_serial_subtractor;

   localparam int W = 8;

   typedef struct packed {
      logic [W-1:0] d;
      logic         b;
   } res_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] minuend;
   logic [W-1:0] subtrahend;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] diff;
   logic         borrow;
   logic         busy;

   res_t sb[$];
   int   total = 0;
   int   bad   = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .minuend    (minuend),
      .subtrahend (subtrahend),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .diff       (diff),
      .borrow     (borrow),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
      end
   endtask

   function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
      res_t r;
      logic [W:0] full;
      full = {1'b0, a} - {1'b0, b};
      r.d  = full[W-1:0];
      r.b  = (a < b);
`ifdef SERIAL_SUB_SAT_EN
      if (r.b) r.d = '0;
`endif
      return r;
   endfunction

   // Presents operands, waits WIDTH edges, holds out_ready low for 'hold' cycles, then completes the handshake.
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold, input bit noisy);
      int   n;
      res_t e;
      minuend    = a;
      subtrahend = b;
      in_valid   = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("in_ready_idle", in_ready, 1);
      @(posedge clk);
      sb.push_back(model(a, b));
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 50) begin
         check("busy_run", busy, 1);
         check("in_ready_run", in_ready, 0);
         if (noisy) begin
            in_valid   = ~in_valid;
            minuend    = W'($urandom);
            subtrahend = W'($urandom);
         end
         @(negedge clk);
         n++;
      end
      in_valid = 1'b0;
      check("latency", n, W);
      for (int i = 0; i < hold; i++) begin
         check("hold_valid", out_valid, 1);
         check("hold_in_ready", in_ready, 0);
         check("hold_diff", diff, sb[0].d);
         check("hold_borrow", borrow, sb[0].b);
         @(negedge clk);
      end
      out_ready = 1'b1;
      if (sb.size() == 0) begin
         check("sb_empty", 0, 1);
      end else begin
         e = sb.pop_front();
         check("out_valid", out_valid, 1);
         check("diff", diff, e.d);
         check("borrow", borrow, e.b);
      end
      @(negedge clk);
      out_ready = 1'b0;
      check("valid_drop", out_valid, 0);
      check("in_ready_back", in_ready, 1);
      check("busy_idle", busy, 0);
   endtask

   initial begin
      rst        = 1'b1;
      in_valid   = 1'b0;
      out_ready  = 1'b0;
      minuend    = '0;
      subtrahend = '0;
      repeat (2) @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_diff", diff, 0);
      check("rst_borrow", borrow, 0);
      check("rst_busy", busy, 0);
      check("rst_in_ready", in_ready, 0);
      rst = 1'b0;
      @(negedge clk);

      // out_ready outside DONE must have no effect
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_ready_valid", out_valid, 0);
      check("idle_ready_in", in_ready, 1);
      out_ready = 1'b0;

      do_op(8'h05, 8'h03, 0, 1'b0);
      do_op(8'h03, 8'h05, 0, 1'b0);
      do_op(8'h00, 8'h00, 0, 1'b0);
      do_op(8'hFF, 8'hFF, 0, 1'b0);
      do_op(8'h00, 8'h01, 0, 1'b0);
      do_op(8'h9C, 8'h3A, 5, 1'b0);
      do_op(8'h11, 8'hE7, 0, 1'b1);
      for (int k = 0; k < 8; k++) begin
         do_op(W'($urandom), W'($urandom), k % 3, k[0]);
      end

      // Abandon an operation after 4 RUN edges
      minuend    = 8'h5A;
      subtrahend = 8'h21;
      in_valid   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      check("midrun_busy", busy, 0);
      check("midrun_valid", out_valid, 0);
      check("midrun_in_ready", in_ready, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check("post_rst_valid", out_valid, 0);
      end
      check("post_rst_in_ready", in_ready, 1);
      do_op(8'h80, 8'h01, 0, 1'b0);

      check("sb_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
